// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the SRAM port arbiter slice.
//   - arb_state_t : sequencer states (S_INIT only used when SRAM_ARB_INIT_EN
//                   is defined, S_SERVE otherwise the only live state)
//   - NUM_REQ     : number of requesters sharing the SRAM port
//   - sram_req_t  : request bundle {addr, we, wdata} for the default geometry
//                   (32-bit words, 1024 deep, one 32-bit write granule)
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int NUM_REQ        = 2;

    localparam int ARB_DATA_WIDTH = 32;
    localparam int ARB_DATA_DEPTH = 1024;
    localparam int ARB_BYTE_SIZE  = 32;
    localparam int ARB_ADDR_WIDTH = $clog2(ARB_DATA_DEPTH);
    localparam int ARB_MASK_WIDTH = ARB_DATA_WIDTH / ARB_BYTE_SIZE;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_SERVE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_WIDTH-1:0] addr;
        logic [ARB_MASK_WIDTH-1:0] we;
        logic [ARB_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter. A lone valid requester is granted at once;
//   when both are valid the requester named by the priority pointer wins.
//   After every grant the pointer moves to the other requester.
//
//   Ports
//     clk, rst_n  : clock, asynchronous active-low reset
//     enable      : arbitration allowed this cycle (grant forced to 0 if low)
//     valid[1:0]  : request valid per requester
//     grant[1:0]  : one-hot grant, or zero when nothing is granted
//     grant_idx   : index of the granted requester (meaningful when |grant)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic prio_q;

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        if (enable) begin
            unique case (valid)
                2'b01: begin
                    grant     = 2'b01;
                    grant_idx = 1'b0;
                end
                2'b10: begin
                    grant     = 2'b10;
                    grant_idx = 1'b1;
                end
                2'b11: begin
                    grant     = prio_q ? 2'b10 : 2'b01;
                    grant_idx = prio_q;
                end
                default: ;
            endcase
        end
    end

    // Pointer always moves away from whoever was just served, so a requester
    // that lost a tie is guaranteed to win the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (|grant) begin
            prio_q <= ~grant_idx;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one port of a dual-port SRAM between two requesters with
//   round-robin arbitration, one access per cycle. Read data comes back on a
//   shared bus one cycle after the grant, straight from the SRAM output.
//
//   Build option: define SRAM_ARB_INIT_EN to add a post-reset zero-fill sweep
//   (S_INIT) that writes 0 to every word before requests are accepted.
//
//   Handshake: a request transfers in the cycle where req_valid_i[k] and
//   req_ready_o[k] are both high. The requester holds valid/addr/we/wdata
//   until ready. A granted read (we == 0) answers with resp_valid_o[k] in the
//   next cycle; the data on resp_rdata_o is only valid in that cycle.
//
//   Ports
//     clk, rst_n        : clock, asynchronous active-low reset
//     req_valid_i[k]    : request valid, requester k
//     req_ready_o[k]    : grant, one-hot or zero
//     req_addr_i[k]     : word address
//     req_we_i[k]       : write granule mask, all-zero = read
//     req_wdata_i[k]    : write data
//     resp_valid_o[k]   : read response valid for requester k
//     resp_rdata_o      : read data (shared)
//     sram_*            : SRAM port (1-cycle read latency)
//     init_done_o       : block is accepting requests
// -----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 1024,
    parameter int BYTE_SIZE  = 32
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic [NUM_REQ-1:0]                                     req_valid_i,
    output logic [NUM_REQ-1:0]                                     req_ready_o,
    input  logic [NUM_REQ-1:0][$clog2(DATA_DEPTH)-1:0]             req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/BYTE_SIZE-1:0]           req_we_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]                     req_wdata_i,
    output logic [NUM_REQ-1:0]                                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]                                  resp_rdata_o,
    output logic                                                   sram_en_o,
    output logic [$clog2(DATA_DEPTH)-1:0]                          sram_addr_o,
    output logic [DATA_WIDTH/BYTE_SIZE-1:0]                        sram_we_o,
    output logic [DATA_WIDTH-1:0]                                  sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                                  sram_rdata_i,
    output logic                                                   init_done_o
);

    localparam int ADDR_W = $clog2(DATA_DEPTH);
    localparam int MASK_W = DATA_WIDTH / BYTE_SIZE;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [MASK_W-1:0]     we;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    arb_state_t         state;
    logic               serve_en;
    logic [NUM_REQ-1:0] grant;
    logic               grant_idx;
    req_t               sel;
    logic [NUM_REQ-1:0] resp_valid_q;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
`ifdef SRAM_ARB_INIT_EN
    arb_state_t        state_q;
    logic [ADDR_W-1:0] sweep_cnt_q;
    logic              init_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            sweep_cnt_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    sweep_cnt_q <= sweep_cnt_q + 1'b1;
                    if (sweep_cnt_q == ADDR_W'(DATA_DEPTH - 1)) begin
                        state_q     <= S_SERVE;
                        init_done_q <= 1'b1;
                    end
                end
                S_SERVE: ;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign state       = state_q;
    assign init_done_o = init_done_q;
`else
    assign state       = S_SERVE;
    assign init_done_o = 1'b1;
`endif

    // Qualifying with rst_n keeps the SRAM port and grants quiet while reset
    // is held, even though the FSM already sits in its reset state.
    assign serve_en = rst_n && (state == S_SERVE);

    // -------------------------------------------------------------------------
    // Arbitration and request select
    // -------------------------------------------------------------------------
    rr_arbiter2 u_rr_arbiter2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (serve_en),
        .valid     (req_valid_i),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel.addr  = req_addr_i[grant_idx];
        sel.we    = req_we_i[grant_idx];
        sel.wdata = req_wdata_i[grant_idx];
    end

    assign req_ready_o = grant;

    // -------------------------------------------------------------------------
    // SRAM port drive (same cycle as the grant)
    // -------------------------------------------------------------------------
    always_comb begin
        sram_en_o    = 1'b0;
        sram_addr_o  = '0;
        sram_we_o    = '0;
        sram_wdata_o = '0;
`ifdef SRAM_ARB_INIT_EN
        if (rst_n && (state == S_INIT)) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = sweep_cnt_q;
            sram_we_o    = '1;
            sram_wdata_o = '0;
        end else
`endif
        if (|grant) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = sel.addr;
            sram_we_o    = sel.we;
            sram_wdata_o = sel.wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read response: one cycle after a read grant, data passed straight through
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= (sel.we == '0) ? grant : '0;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = sram_rdata_i;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Single-port sequencer and arbiter in front of one port of the team's dual-port SRAM (`dpsram`).
- Shares that port between two requesters, req0 (e.g. refill/store path) and req1 (e.g. snoop/probe path), using round-robin arbitration and one access per cycle.
- Returns read data one cycle after grant, matching the SRAM's 1-cycle read latency.
- Optionally runs a post-reset zero-fill sweep so the memory starts in a known state.

Parameters:
- DATA_WIDTH, 32, SRAM word width in bits.
- DATA_DEPTH, 1024, number of SRAM words.
- BYTE_SIZE, 32, write-enable granule in bits; the write mask is DATA_WIDTH/BYTE_SIZE bits wide.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  2  per-requester request valid; index k = requester k.
- req_ready_o  out  2  per-requester grant; one-hot or zero.
- req_addr_i  in  2 x $clog2(DATA_DEPTH)  per-requester word address.
- req_we_i  in  2 x (DATA_WIDTH/BYTE_SIZE)  per-requester write mask; all-zero means read.
- req_wdata_i  in  2 x DATA_WIDTH  per-requester write data.
- resp_valid_o  out  2  read response valid for requester k.
- resp_rdata_o  out  DATA_WIDTH  read data, shared bus, qualified by resp_valid_o.
- sram_en_o  out  1  SRAM port enable.
- sram_addr_o  out  $clog2(DATA_DEPTH)  SRAM address.
- sram_we_o  out  DATA_WIDTH/BYTE_SIZE  SRAM write mask.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data; 1-cycle latency, write_first.
- init_done_o  out  1  high once the block accepts requests.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- FSM states:
  - INIT: zero-fill sweep, present only with the macro.
  - SERVE.
  - Reset enters INIT when the macro is defined, otherwise SERVE.
- Reset values:
  - req_ready_o = 0, resp_valid_o = 0.
  - sram_en_o = 0, sram_we_o = 0.
  - init_done_o = 0 with the macro, 1 without.
  - Round-robin pointer prio_q = 0; sweep counter = 0.
- SERVE arbitration (combinational each cycle):
  - Only one requester valid: grant it.
  - Both valid: grant requester prio_q.
  - req_ready_o is one-hot for the granted requester and 0 when neither is valid. A transfer is valid && ready.
- Pointer update: after any grant, prio_q <= ~granted index. With no grant, prio_q holds.
- SRAM drive on a grant:
  - sram_en_o = 1, sram_addr_o = req_addr_i[g], sram_we_o = req_we_i[g], sram_wdata_o = req_wdata_i[g].
  - Same cycle as the grant; no added latency.
  - With no grant: sram_en_o = 0, sram_we_o = 0.
- Read response (we == 0 granted in cycle T):
  - resp_valid_o[g] is registered high in cycle T+1.
  - resp_rdata_o = sram_rdata_i (pass-through), valid only while resp_valid_o is high.
  - The requester must sample it in T+1; the block does not hold the data.
- Writes (any we bit set) produce no response. The SRAM's write_first return is ignored.
- Back-to-back grants are allowed every cycle; resp_valid_o may be high in consecutive cycles for alternating requesters.
- Read-after-write to the same address in consecutive cycles returns the new data (SRAM ordering is sufficient).
- A partial-mask write is forwarded unchanged; masked-off granules keep their old value.
- A request must hold valid/addr/we/wdata stable until ready. The block does not check this.
- Reset asserted mid-operation: outputs clear immediately, any pending response is dropped, the FSM returns to its reset state, and the sweep restarts from 0.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN.
- Defined:
  - Reset enters INIT. Each cycle: sram_en_o = 1, sram_we_o = all-ones, sram_wdata_o = 0, sram_addr_o = counter.
  - The counter runs 0 .. DATA_DEPTH-1; after the last address the FSM moves to SERVE and init_done_o <= 1.
  - req_ready_o = 0 throughout INIT. The sweep takes exactly DATA_DEPTH cycles.
- Undefined:
  - No INIT state and no sweep counter; init_done_o = 1 from reset release.
  - Memory contents are whatever the SRAM powers up with.

Decomposition:
- Shared package sram_arb_pkg holds:
  - FSM state typedef (S_INIT, S_SERVE).
  - Requester count constant NUM_REQ = 2.
  - Request struct typedef {addr, we, wdata} parameterised through localparams.
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant with priority pointer.
- The sweep counter and response register stay in the top module.

Test Plan:
- Init sweep with DATA_DEPTH = 16 and the macro on: reset released → 16 consecutive cycles of zero-writes to addresses 0..15 with we all-ones; init_done_o rises in cycle 17; then a read of address 5 returns 0.
- Single requester: req0 writes 0xDEADBEEF to address 3, then reads address 3 → resp_valid_o = 2'b01 exactly one cycle after the read grant, resp_rdata_o = 0xDEADBEEF.
- Contention: both requesters valid continuously, reading addresses 1 and 2 → grants alternate 0,1,0,1 starting with 0; resp_valid_o alternates 01,10 one cycle later with the matching data.
- Pointer fairness: req1 alone granted, then both valid → req0 granted next.
- Partial write with BYTE_SIZE = 8 (mask width 4): address 7 holds 0x11223344; write mask 4'b0010 with data 0xAABBCCDD → read returns 0x1122CC44.
- Reset mid-sweep at address 6, plus a reset the cycle after a read grant → no resp_valid_o pulse; after release the sweep restarts at address 0.
